// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file.
// Registered reads (1-cycle latency), optional hardwired zero entry and a
// sequential clear engine that zeroes every entry after reset before o_ready.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding on a
// same-cycle read/write collision).
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [XLEN-1:0]    i_wdata,
  input  logic [NR*AW-1:0]   i_raddr,
  output logic [NR*XLEN-1:0] o_rdata,
  output logic               o_ready
);

  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam bit            ZR   = (ZERO_REG != 0);

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [NR*XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0]    mem [DEPTH];

  logic               mem_we;
  logic [AW-1:0]      mem_wa;
  logic [XLEN-1:0]    mem_wd;
  logic [AW-1:0]      raddr;

  // Next-state, clear-engine write port and read-data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    mem_wa  = i_waddr;
    mem_wd  = i_wdata;
    raddr   = '0;
    unique case (state_q)
      CLEAR: begin
        // The clear engine owns the write port; user writes are dropped.
        mem_we  = 1'b1;
        mem_wa  = cnt_q;
        mem_wd  = '0;
        cnt_d   = cnt_q + AW'(1);
        rdata_d = '0;
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        mem_we = i_we && !(ZR && (i_waddr == '0));
        for (int unsigned k = 0; k < NR; k++) begin
          raddr = i_raddr[k*AW +: AW];
          if (ZR && (raddr == '0)) begin
            rdata_d[k*XLEN +: XLEN] = '0;
          end
`ifdef REGFILE_BYPASS_EN
          else if (i_we && (raddr == i_waddr)) begin
            rdata_d[k*XLEN +: XLEN] = i_wdata;
          end
`endif
          else begin
            rdata_d[k*XLEN +: XLEN] = mem[raddr];
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    // Reset cycle leaves the array untouched and drops any pending write.
    if (i_rst) mem_we = 1'b0;
  end

  // State, clear counter and registered read data with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: no reset, zeroed by the clear engine.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign o_rdata = rdata_q;
  assign o_ready = (state_q == RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build plus a
// DEPTH=16 / NR=4 / ZERO_REG=0 instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance.
  logic        rst, we, ready;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  // Swept configuration instance.
  logic         rst2, we2, ready2;
  logic [3:0]   waddr2;
  logic [31:0]  wdata2;
  logic [15:0]  raddr2;
  logic [127:0] rdata2;

  regfile_mp dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (we),
    .i_waddr(waddr),
    .i_wdata(wdata),
    .i_raddr(raddr),
    .o_rdata(rdata),
    .o_ready(ready)
  );

  regfile_mp #(.XLEN(32), .DEPTH(16), .NR(4), .ZERO_REG(0)) dut2 (
    .i_clk  (clk),
    .i_rst  (rst2),
    .i_we   (we2),
    .i_waddr(waddr2),
    .i_wdata(wdata2),
    .i_raddr(raddr2),
    .o_rdata(rdata2),
    .o_ready(ready2)
  );

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h2;
`else
  localparam logic [31:0] COLL_EXP = 32'h1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int k);
    return rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rd2(input int k);
    return rdata2[k*32 +: 32];
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    rst2 = 1'b1; we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

    // Two reset cycles.
    step();
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd0", rd(0), 32'd0);
    check("rst_rd1", rd(1), 32'd0);
    check("rst_ready2", {31'd0, ready2}, 32'd0);

    // Clear sequence: ready after the 32nd (resp. 16th) posedge.
    rst = 1'b0; rst2 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("clr_ready_%0d", i), {31'd0, ready}, (i >= 32) ? 32'd1 : 32'd0);
      check($sformatf("clr_ready2_%0d", i), {31'd0, ready2}, (i >= 16) ? 32'd1 : 32'd0);
      if (i == 20) check("clr_rd0_held", rd(0), 32'd0);
    end

    // Every entry reads zero after the clear.
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      step();
      check($sformatf("init_x%0d", a), rd(0), 32'd0);
      check($sformatf("init_x%0d", a + 1), rd(1), 32'd0);
    end

    // Basic write then dual-port read of x5.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr = {5'd5, 5'd5};
    step();
    check("x5_p0", rd(0), 32'hDEADBEEF);
    check("x5_p1", rd(1), 32'hDEADBEEF);

    // x0 is hardwired to zero.
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    step();
    we = 1'b0; raddr = {5'd5, 5'd0};
    step();
    check("x0_p0", rd(0), 32'd0);
    check("x0_x5_p1", rd(1), 32'hDEADBEEF);

    // Same-cycle read/write collision on x7.
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    step();
    wdata = 32'h2; raddr = {5'd0, 5'd7};
    step();
    we = 1'b0;
    check("coll_same", rd(0), COLL_EXP);
    check("coll_p1_x0", rd(1), 32'd0);
    step();
    check("coll_next", rd(0), 32'h2);

    // Fill x1..x31 with their index.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    we = 1'b0; raddr = {5'd1, 5'd31};
    step();
    check("fill_x31", rd(0), 32'd31);
    check("fill_x1", rd(1), 32'd1);
    raddr = {5'd3, 5'd4};
    step();
    check("fill_x4", rd(0), 32'd4);
    check("fill_x3", rd(1), 32'd3);

    // Reset during RUN with a concurrent write that must be dropped.
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    step();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_rd0", rd(0), 32'd0);
    check("mid_rst_rd1", rd(1), 32'd0);
    // Write during clear is lost.
    rst = 1'b0; waddr = 5'd3; wdata = 32'h33;
    step();
    we = 1'b0;
    check("mid_clr_ready_1", {31'd0, ready}, 32'd0);
    for (int i = 2; i <= 10; i++) begin
      step();
      check($sformatf("mid_clr_ready_%0d", i), {31'd0, ready}, 32'd0);
    end
    // Reset again with the clear counter at 10.
    rst = 1'b1;
    step();
    check("cnt10_rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("reclr_ready_%0d", i), {31'd0, ready}, (i >= 32) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 32; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      step();
      check($sformatf("reclr_x%0d", a), rd(0), 32'd0);
      check($sformatf("reclr_x%0d", a + 1), rd(1), 32'd0);
    end

    // Swept instance: entry 0 is an ordinary register.
    check("d2_ready", {31'd0, ready2}, 32'd1);
    we2 = 1'b1; waddr2 = 4'd0; wdata2 = 32'hA5A5A5A5; raddr2 = '0;
    step();
    we2 = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d2_x0_p%0d", k), rd2(k), 32'hA5A5A5A5);
    end
    we2 = 1'b1; waddr2 = 4'd15; wdata2 = 32'h0F0F0001;
    step();
    we2 = 1'b0; raddr2 = {4'd0, 4'd15, 4'd1, 4'd15};
    step();
    check("d2_p0_x15", rd2(0), 32'h0F0F0001);
    check("d2_p1_x1", rd2(1), 32'd0);
    check("d2_p2_x15", rd2(2), 32'h0F0F0001);
    check("d2_p3_x0", rd2(3), 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
